// File: rtl/data_ram.sv
// Data-side memory responder for the CPU MEM stage: accepts one access, holds the
// pipeline for WAIT_CYCLES wait states, then answers with read data, ack and error.
module data_ram #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stallreq_o,
  output logic [1:0]  o_dbg_state
);

  localparam int         DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Handshake: ce_i is a level request held stable while stallreq_o is high.
  // ack_o pulses for the single RESP cycle; the pipeline advances at its end.
  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_wdata;
  logic [31:0] r_data_o;
  logic        r_ack;
  logic        r_err;

  logic [31:0] r_mem [DEPTH];

  logic                  w_in_idle;
  logic                  w_in_busy;
  logic                  w_go_resp;
  logic [31:0]           w_op_addr;
  logic                  w_op_we;
  logic [3:0]            w_op_sel;
  logic [31:0]           w_op_wdata;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_err;

  assign w_in_idle = (r_state == S_IDLE);
  assign w_in_busy = (r_state == S_BUSY);

  // Response work is done on the edge that enters RESP, so data/ack are valid
  // throughout RESP. With zero wait states that edge is the accept edge itself,
  // hence operands come straight from the inputs while in IDLE.
  assign w_go_resp = (w_in_idle && ce_i && (LP_WAIT == 4'd0)) ||
                     (w_in_busy && ce_i && (r_cnt == 4'd1));

  assign w_op_addr  = w_in_idle ? addr_i : r_addr;
  assign w_op_we    = w_in_idle ? we_i   : r_we;
  assign w_op_sel   = w_in_idle ? sel_i  : r_sel;
  assign w_op_wdata = w_in_idle ? data_i : r_wdata;

  assign w_idx = w_op_addr[ADDR_WIDTH+1:2];
  assign w_err = (w_op_addr[1:0] != 2'b00) || (|(w_op_addr >> (ADDR_WIDTH + 2)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= 32'd0;
      r_we     <= 1'b0;
      r_sel    <= 4'd0;
      r_wdata  <= 32'd0;
      r_data_o <= 32'd0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ce_i) begin
            r_addr  <= addr_i;
            r_we    <= we_i;
            r_sel   <= sel_i;
            r_wdata <= data_i;
            if (LP_WAIT == 4'd0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= LP_WAIT;
            end
          end
        end
        S_BUSY: begin
          // Dropping ce_i mid-wait abandons the access with no write and no ack.
          if (!ce_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase

      if (w_go_resp) begin
        r_ack <= 1'b1;
        r_err <= w_err;
        if (w_err) begin
          r_data_o <= 32'd0;
        end else if (!w_op_we) begin
          r_data_o <= r_mem[w_idx];
        end
      end
    end
  end

  // Array has no reset; contents survive rst, and reset on the response edge blocks the write.
  always_ff @(posedge clk) begin
    if (rst && w_go_resp && w_op_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_op_sel[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_op_wdata[8*b +: 8];
        end
      end
    end
  end

  assign data_o      = r_data_o;
  assign ack_o       = r_ack;
  assign err_o       = r_err;
  assign stallreq_o  = (w_in_idle && ce_i) || w_in_busy;
  assign o_dbg_state = r_state;

endmodule
